// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, rx state type and frame length decode
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  localparam logic [2:0] FRAME_5bit = 3'b000;
  localparam logic [2:0] FRAME_6bit = 3'b001;
  localparam logic [2:0] FRAME_7bit = 3'b010;
  localparam logic [2:0] FRAME_8bit = 3'b011;
  localparam logic [2:0] FRAME_9bit = 3'b100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP_1 = 3'd4,
    STOP_2 = 3'd5,
    DONE   = 3'd6
  } rx_state_e;

  // Reserved size codes fall back to a standard 8-bit frame.
  function automatic logic [3:0] frame_len(input logic [2:0] size);
    case (size)
      FRAME_5bit: frame_len = 4'd5;
      FRAME_6bit: frame_len = 4'd6;
      FRAME_7bit: frame_len = 4'd7;
      FRAME_8bit: frame_len = 4'd8;
      FRAME_9bit: frame_len = 4'd9;
      default:    frame_len = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/sync_rx.sv
// rtl/sync_rx.sv - two-flop rx line synchroniser with registered start-arm flag
module sync_rx (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic rx_i,
  input  logic clr_arm_i,
  output logic rxs_o,
  output logic start_o
);

  logic sync1_q;
  logic sync2_q;
  logic armed_q;
  logic armed_d;

  always_comb begin
    armed_d = armed_q;
    if (clr_arm_i) begin
      armed_d = 1'b0;
    end else if (sync2_q) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      armed_q <= armed_d;
    end
  end

  assign rxs_o = sync2_q;
  // A low line only counts as a start once it has been seen high since the last frame,
  // so a held-low break cannot retrigger.
  assign start_o = armed_q & ~sync2_q;

endmodule

// File: rtl/recv.sv
// rtl/recv.sv - UART receive engine; RECV_MAJORITY_VOTE_EN enables 2-of-3 sample voting
module recv
  import uart_pkg::*;
#(
  parameter int SIZE_DATA     = 9,
  parameter int OVER_SAMPLING = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stick,
  input  logic                 i_rx_en,
  input  logic [2:0]           i_size_frame,
  input  logic [1:0]           i_parity_bit,
  input  logic                 i_stop_bit,
  input  logic                 i_data_rx,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_done_rx,
  output logic                 o_parity_err,
  output logic                 o_frame_err
);

  localparam int TW  = $clog2(OVER_SAMPLING + 1);
  localparam int MID = OVER_SAMPLING / 2;

  logic rxs;
  logic start_det;
  logic clr_arm;
  logic sample;

  sync_rx u_sync_rx (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .rx_i      (i_data_rx),
    .clr_arm_i (clr_arm),
    .rxs_o     (rxs),
    .start_o   (start_det)
  );

`ifdef RECV_MAJORITY_VOTE_EN
  // Voting delays every decision by one tick; later states stay centred because
  // their count starts from that delayed entry.
  localparam int START_DEC = MID + 1;
  logic [1:0] vote_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vote_q <= 2'b11;
    end else if (i_stick) begin
      vote_q <= {vote_q[0], rxs};
    end
  end

  assign sample = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs) | (vote_q[0] & rxs);
`else
  localparam int START_DEC = MID;
  assign sample = rxs;
`endif

  localparam logic [TW-1:0] START_LAST = TW'(START_DEC - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OVER_SAMPLING - 1);

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           idx_q, idx_d;
  logic [SIZE_DATA-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           par_q, par_d;
  logic                 stop_q, stop_d;
  logic [SIZE_DATA-1:0] data_q;
  logic                 done_q;
  logic                 perr_out_q;
  logic                 ferr_out_q;

  logic bit_tick;
  logic par_en;
  logic exp_par;

  assign bit_tick = i_stick && (tick_q == BIT_LAST);
  assign par_en   = (par_q == PARITY_ODD) || (par_q == PARITY_EVEN);
  assign exp_par  = (par_q == PARITY_ODD) ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    size_d  = size_q;
    par_d   = par_q;
    stop_d  = stop_q;
    clr_arm = 1'b0;
    if (i_stick) begin
      tick_d = tick_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (i_rx_en && start_det) begin
          state_d = START;
          size_d  = i_size_frame;
          par_d   = i_parity_bit;
          stop_d  = i_stop_bit;
          shift_d = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          idx_d   = '0;
        end
      end
      START: begin
        if (i_stick && (tick_q == START_LAST)) begin
          tick_d  = '0;
          idx_d   = '0;
          state_d = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          tick_d = '0;
          if (int'(idx_q) < SIZE_DATA) begin
            shift_d[idx_q] = sample;
          end
          if (idx_q == frame_len(size_q) - 4'd1) begin
            state_d = par_en ? PARITY : STOP_1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          tick_d  = '0;
          state_d = STOP_1;
          if (sample != exp_par) begin
            perr_d = 1'b1;
          end
        end
      end
      STOP_1: begin
        if (bit_tick) begin
          tick_d  = '0;
          state_d = stop_q ? STOP_2 : DONE;
          if (!sample) begin
            ferr_d = 1'b1;
          end
        end
      end
      STOP_2: begin
        if (bit_tick) begin
          tick_d  = '0;
          state_d = DONE;
          if (!sample) begin
            ferr_d = 1'b1;
          end
        end
      end
      DONE: begin
        tick_d  = '0;
        clr_arm = 1'b1;
        state_d = IDLE;
      end
      default: begin
        tick_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      size_q     <= '0;
      par_q      <= '0;
      stop_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      size_q  <= size_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      done_q  <= (state_d == DONE);
      // Outputs load on the way into DONE so they line up with the strobe.
      if (state_d == DONE) begin
        data_q     <= shift_d;
        perr_out_q <= perr_d;
        ferr_out_q <= ferr_d;
      end
    end
  end

  assign o_data       = data_q;
  assign o_done_rx    = done_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;

endmodule

// File: tb/tb_recv.sv
// tb/tb_recv.sv - self-checking bench for recv against a serial-frame reference model
module tb_recv;

  localparam int OS = 16;
  localparam int SD = 9;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_stick = 1'b1;
  logic          i_rx_en = 1'b1;
  logic [2:0]    i_size_frame = 3'd3;
  logic [1:0]    i_parity_bit = 2'd0;
  logic          i_stop_bit = 1'b0;
  logic          i_data_rx = 1'b1;
  logic [SD-1:0] o_data;
  logic          o_done_rx;
  logic          o_parity_err;
  logic          o_frame_err;

  int errors = 0;
  int checks = 0;
  logic [10:0] mon_q[$];

  always #5 i_clk = ~i_clk;

  recv #(.SIZE_DATA(SD), .OVER_SAMPLING(OS)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stick      (i_stick),
    .i_rx_en      (i_rx_en),
    .i_size_frame (i_size_frame),
    .i_parity_bit (i_parity_bit),
    .i_stop_bit   (i_stop_bit),
    .i_data_rx    (i_data_rx),
    .o_data       (o_data),
    .o_done_rx    (o_done_rx),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err)
  );

  always @(negedge i_clk) begin
    if (o_done_rx) mon_q.push_back({o_data, o_parity_err, o_frame_err});
  end

  function automatic int nbits_of(input logic [2:0] s);
    return (s <= 3'd4) ? int'(s) + 5 : 8;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1 i_data_rx = 1'b1;
    end
  endtask

  task automatic set_cfg(input logic [2:0] s, input logic [1:0] p, input logic st);
    i_size_frame = s;
    i_parity_bit = p;
    i_stop_bit   = st;
  endtask

  // Serial transmitter model: start, data LSB first, optional parity, stop bit(s).
  task automatic send_frame(input logic [8:0] data, input logic flip_par, input logic stop_low,
                            input int glitch_bit, input int cut);
    logic bits[$];
    logic v;
    int n;
    int ones;
    int cyc;
    n = nbits_of(i_size_frame);
    ones = 0;
    cyc = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (i_parity_bit == 2'b01 || i_parity_bit == 2'b10) begin
      v = (i_parity_bit == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0);
      bits.push_back(v ^ flip_par);
    end
    repeat (i_stop_bit ? 2 : 1) bits.push_back(~stop_low);
    foreach (bits[b]) begin
      for (int c = 0; c < OS; c++) begin
        if (cut > 0 && cyc >= cut) return;
        v = bits[b];
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c == OS / 2) v = ~v;
        @(posedge i_clk);
        #1 i_data_rx = v;
        cyc++;
      end
    end
  endtask

  task automatic test_reset;
    logic [11:0] got;
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 got = {o_data, o_done_rx, o_parity_err, o_frame_err};
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL reset_outputs got=%h exp=000", got); end
    @(negedge i_clk) i_rst_n = 1'b1;
    idle(10);
    checks++;
    if (mon_q.size() != 0) begin errors++; $display("FAIL reset_no_done got=%0d exp=0", mon_q.size()); end
  endtask

  task automatic test_8n1;
    logic [10:0] w;
    set_cfg(3'd3, 2'd0, 1'b0);
    send_frame(9'h0A5, 1'b0, 1'b0, -1, 0);
    idle(24);
    checks++;
    if (mon_q.size() != 1) begin errors++; $display("FAIL 8n1_count got=%0d exp=1", mon_q.size()); end
    else begin
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h0A5, 2'b00}) begin errors++; $display("FAIL 8n1_word got=%h exp=%h", w, {9'h0A5, 2'b00}); end
    end
  endtask

  task automatic test_5e2;
    logic [10:0] w;
    set_cfg(3'd0, 2'd2, 1'b1);
    for (int f = 0; f < 2; f++) begin
      mon_q.delete();
      send_frame(9'h016, f[0], 1'b0, -1, 0);
      idle(24);
      checks++;
      if (mon_q.size() != 1) begin errors++; $display("FAIL 5e2_count[%0d] got=%0d exp=1", f, mon_q.size()); end
      else begin
        w = mon_q.pop_front();
        checks++;
        if (w !== {9'h016, f[0], 1'b0}) begin errors++; $display("FAIL 5e2_word[%0d] got=%h exp=%h", f, w, {9'h016, f[0], 1'b0}); end
      end
    end
  endtask

  task automatic test_9o1_frame_err;
    logic [10:0] w;
    mon_q.delete();
    set_cfg(3'd4, 2'd1, 1'b0);
    send_frame(9'h1FF, 1'b0, 1'b0, -1, 0);
    idle(24);
    set_cfg(3'd3, 2'd0, 1'b0);
    send_frame(9'h081, 1'b0, 1'b1, -1, 0);
    idle(40);
    checks++;
    if (mon_q.size() != 2) begin errors++; $display("FAIL 9o1_ferr_count got=%0d exp=2", mon_q.size()); end
    else begin
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h1FF, 2'b00}) begin errors++; $display("FAIL 9o1_word got=%h exp=%h", w, {9'h1FF, 2'b00}); end
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h081, 2'b01}) begin errors++; $display("FAIL ferr_word got=%h exp=%h", w, {9'h081, 2'b01}); end
    end
  endtask

  task automatic test_start_glitch;
    logic [10:0] w;
    mon_q.delete();
    set_cfg(3'd3, 2'd0, 1'b0);
    repeat (5) begin @(posedge i_clk); #1 i_data_rx = 1'b0; end
    idle(60);
    checks++;
    if (mon_q.size() != 0) begin errors++; $display("FAIL glitch_no_done got=%0d exp=0", mon_q.size()); end
    send_frame(9'h03C, 1'b0, 1'b0, -1, 0);
    idle(24);
    checks++;
    if (mon_q.size() != 1) begin errors++; $display("FAIL glitch_next_count got=%0d exp=1", mon_q.size()); end
    else begin
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h03C, 2'b00}) begin errors++; $display("FAIL glitch_next_word got=%h exp=%h", w, {9'h03C, 2'b00}); end
    end
  endtask

  task automatic test_break;
    logic [10:0] w;
    mon_q.delete();
    set_cfg(3'd3, 2'd0, 1'b0);
    repeat (20 * OS) begin @(posedge i_clk); #1 i_data_rx = 1'b0; end
    checks++;
    if (mon_q.size() != 1) begin errors++; $display("FAIL break_count got=%0d exp=1", mon_q.size()); end
    else begin
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h000, 2'b01}) begin errors++; $display("FAIL break_word got=%h exp=%h", w, {9'h000, 2'b01}); end
    end
    idle(40);
    send_frame(9'h096, 1'b0, 1'b0, -1, 0);
    idle(24);
    w = (mon_q.size() == 1) ? mon_q.pop_front() : 11'h7FF;
    checks++;
    if (w !== {9'h096, 2'b00}) begin errors++; $display("FAIL break_next_word got=%h exp=%h", w, {9'h096, 2'b00}); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] w;
    mon_q.delete();
    set_cfg(3'd3, 2'd0, 1'b1);
    send_frame(9'h000, 1'b0, 1'b0, -1, 0);
    send_frame(9'h0FF, 1'b0, 1'b0, -1, 0);
    idle(24);
    checks++;
    if (mon_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", mon_q.size()); end
    else begin
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h000, 2'b00}) begin errors++; $display("FAIL b2b_first got=%h exp=%h", w, {9'h000, 2'b00}); end
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h0FF, 2'b00}) begin errors++; $display("FAIL b2b_second got=%h exp=%h", w, {9'h0FF, 2'b00}); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [11:0] got;
    logic [10:0] w;
    mon_q.delete();
    set_cfg(3'd3, 2'd0, 1'b0);
    send_frame(9'h0C3, 1'b0, 1'b0, -1, 4 * OS);
    #2 i_rst_n = 1'b0;
    #1 got = {o_data, o_done_rx, o_parity_err, o_frame_err};
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL rstmid_async got=%h exp=000", got); end
    i_data_rx = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 got = {o_data, o_done_rx, o_parity_err, o_frame_err};
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL rstmid_hold got=%h exp=000", got); end
    @(negedge i_clk) i_rst_n = 1'b1;
    idle(40);
    send_frame(9'h055, 1'b0, 1'b0, -1, 0);
    idle(24);
    checks++;
    if (mon_q.size() != 1) begin errors++; $display("FAIL rstmid_count got=%0d exp=1", mon_q.size()); end
    else begin
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h055, 2'b00}) begin errors++; $display("FAIL rstmid_word got=%h exp=%h", w, {9'h055, 2'b00}); end
    end
  endtask

  task automatic test_rx_en;
    logic [10:0] w;
    mon_q.delete();
    set_cfg(3'd3, 2'd0, 1'b0);
    fork
      send_frame(9'h0E7, 1'b0, 1'b0, -1, 0);
      begin repeat (3 * OS) @(posedge i_clk); #2 i_rx_en = 1'b0; end
    join
    idle(24);
    send_frame(9'h077, 1'b0, 1'b0, -1, 0);
    idle(24);
    i_rx_en = 1'b1;
    checks++;
    if (mon_q.size() != 1) begin errors++; $display("FAIL rx_en_count got=%0d exp=1", mon_q.size()); end
    else begin
      w = mon_q.pop_front();
      checks++;
      if (w !== {9'h0E7, 2'b00}) begin errors++; $display("FAIL rx_en_word got=%h exp=%h", w, {9'h0E7, 2'b00}); end
    end
  endtask

  task automatic test_bit_glitch;
    logic [10:0] w;
    logic [8:0] exp_d;
    mon_q.delete();
    set_cfg(3'd3, 2'd0, 1'b0);
`ifdef RECV_MAJORITY_VOTE_EN
    exp_d = 9'h05A;
`else
    exp_d = 9'h052;
`endif
    send_frame(9'h05A, 1'b0, 1'b0, 3, 0);
    idle(24);
    w = (mon_q.size() == 1) ? mon_q.pop_front() : 11'h7FF;
    checks++;
    if (w !== {exp_d, 2'b00}) begin errors++; $display("FAIL bit_glitch got=%h exp=%h", w, {exp_d, 2'b00}); end
  endtask

  task automatic test_random;
    logic [10:0] w;
    logic [10:0] exp_w;
    logic [8:0] d;
    logic flip;
    logic slow;
    int n;
    for (int k = 0; k < 20; k++) begin
      mon_q.delete();
      set_cfg(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      d = 9'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      slow = ($urandom_range(0, 3) == 0);
      n = nbits_of(i_size_frame);
      exp_w = {d & 9'((1 << n) - 1), flip && (i_parity_bit == 2'b01 || i_parity_bit == 2'b10), slow};
      send_frame(d, flip, slow, -1, 0);
      idle(30);
      w = (mon_q.size() == 1) ? mon_q.pop_front() : 11'h7FF;
      checks++;
      if (w !== exp_w) begin
        errors++;
        $display("FAIL random[%0d] size=%0d par=%0d stop=%0d got=%h exp=%h", k, i_size_frame, i_parity_bit, i_stop_bit, w, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_5e2();
    test_9o1_frame_err();
    test_start_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_rx_en();
    test_bit_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
